// File: rtl/fetch_if.sv
// Fetch-stage bus: pipeline control in, instruction memory port, IF/ID register out.
// The fetch stage connects through the slave modport; the driving side uses master.
interface fetch_if #(
   parameter int IMEM_AW = 8
);
   logic               stall;
   logic               flush;
   logic               br_taken;
   logic [31:0]        br_target;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_inst;
   logic [31:0]        pc;
   logic [31:0]        if_pc;
   logic [31:0]        if_inst;
   logic               if_valid;
   logic               halted;
   logic [15:0]        fetch_count;

   modport master (
      output stall, flush, br_taken, br_target, imem_inst,
      input  imem_addr, pc, if_pc, if_inst, if_valid, halted, fetch_count
   );

   modport slave (
      input  stall, flush, br_taken, br_target, imem_inst,
      output imem_addr, pc, if_pc, if_inst, if_valid, halted, fetch_count
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem address and IF/ID register; word visible one edge after its PC.
// Priority rst > br_taken > flush > stall; halt-word freeze compiled in by FETCH_HALT_EN.
module fetch_stage #(
   parameter int          IMEM_AW   = 8,
   parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
   input logic    clk,
   input logic    rst,
   fetch_if.slave bus
);
`ifdef FETCH_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   typedef enum logic {RUN, HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic        if_valid_q, if_valid_d;
   logic [15:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         pc_q       <= 32'd0;
         if_pc_q    <= 32'd0;
         if_inst_q  <= 32'd0;
         if_valid_q <= 1'b0;
         cnt_q      <= 16'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
         if_valid_q <= if_valid_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if_valid_d = if_valid_q;
      cnt_d      = cnt_q;
      if (bus.br_taken) begin
         pc_d       = bus.br_target;
         if_pc_d    = 32'd0;
         if_inst_d  = 32'd0;
         if_valid_d = 1'b0;
         state_d    = RUN;
      end else if (state_q == HALT) begin
         if_pc_d    = 32'd0;
         if_inst_d  = 32'd0;
         if_valid_d = 1'b0;
      end else if (bus.flush) begin
         if_pc_d    = 32'd0;
         if_inst_d  = 32'd0;
         if_valid_d = 1'b0;
         if (!bus.stall) pc_d = pc_q + 32'd1;
      end else if (bus.stall) begin
         pc_d = pc_q;
      end else if (HALT_EN && (bus.imem_inst == HALT_WORD)) begin
         // Halt word is squashed and the PC parks on its address.
         if_pc_d    = 32'd0;
         if_inst_d  = 32'd0;
         if_valid_d = 1'b0;
         state_d    = HALT;
      end else begin
         if_pc_d    = pc_q;
         if_inst_d  = bus.imem_inst;
         if_valid_d = 1'b1;
         pc_d       = pc_q + 32'd1;
         if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
   end

   assign bus.imem_addr   = pc_q[IMEM_AW-1:0];
   assign bus.pc          = pc_q;
   assign bus.if_pc       = if_pc_q;
   assign bus.if_inst     = if_inst_q;
   assign bus.if_valid    = if_valid_q;
   assign bus.fetch_count = cnt_q;
   assign bus.halted      = HALT_EN && (state_q == HALT);
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random control against a rule-level model.
module tb_fetch_stage;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

`ifdef FETCH_HALT_EN
   localparam bit HEN = 1'b1;
`else
   localparam bit HEN = 1'b0;
`endif

   fetch_if #(.IMEM_AW(8)) bus ();
   fetch_stage #(.IMEM_AW(8), .HALT_WORD(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [31:0] imem [256];
   assign bus.imem_inst = imem[bus.imem_addr];

   int total = 0;
   int bad   = 0;

   // Reference state, updated from the rule list of each edge.
   logic [31:0] m_pc, m_ipc, m_inst;
   logic        m_v, m_halt;
   logic [15:0] m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic bubble();
      m_v = 1'b0; m_inst = 32'd0; m_ipc = 32'd0;
   endtask

   task automatic step(input logic r, input logic s, input logic f, input logic b,
                       input logic [31:0] t);
      logic [31:0] w;
      rst = r; bus.stall = s; bus.flush = f; bus.br_taken = b; bus.br_target = t;
      w = imem[m_pc[7:0]];
      if (r) begin
         m_pc = 0; bubble(); m_halt = 0; m_cnt = 0;
      end else if (b) begin
         m_pc = t; bubble(); m_halt = 0;
      end else if (m_halt) begin
         bubble();
      end else if (f) begin
         bubble();
         if (!s) m_pc = m_pc + 1;
      end else if (s) begin
         // everything held
      end else if (HEN && w == 32'h0) begin
         bubble(); m_halt = 1;
      end else begin
         m_v = 1; m_inst = w; m_ipc = m_pc; m_pc = m_pc + 1;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      end
      @(posedge clk);
      #1;
      check("pc", bus.pc, m_pc);
      check("imem_addr", {24'd0, bus.imem_addr}, {24'd0, m_pc[7:0]});
      check("if_pc", bus.if_pc, m_ipc);
      check("if_inst", bus.if_inst, m_inst);
      check("if_valid", {31'd0, bus.if_valid}, {31'd0, m_v});
      check("halted", {31'd0, bus.halted}, {31'd0, m_halt});
      check("fetch_count", {16'd0, bus.fetch_count}, {16'd0, m_cnt});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'd0);
   endtask

   initial begin
      rst = 1'b1; bus.stall = 0; bus.flush = 0; bus.br_taken = 0; bus.br_target = 0;
      m_pc = 0; m_ipc = 0; m_inst = 0; m_v = 0; m_halt = 0; m_cnt = 0;
      for (int i = 0; i < 256; i++) imem[i] = $urandom | 32'h1;
      for (int i = 0; i < 4; i++) imem[i] = 32'h5000_0001 + i;
      imem[5] = 32'h0;

      // Reset, then free-run four fetches.
      step(1, 0, 0, 0, 0);
      check("rst_valid", {31'd0, bus.if_valid}, 32'd0);
      check("rst_pc", bus.pc, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 0);
         check("seq_inst", bus.if_inst, 32'h5000_0001 + i);
         check("seq_ipc", bus.if_pc, i);
      end
      check("seq_pc", bus.pc, 32'd4);
      check("seq_cnt", {16'd0, bus.fetch_count}, 32'd4);

      // Stall three cycles at pc=2.
      step(1, 0, 0, 0, 0);
      run(2);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      check("stall_pc", bus.pc, 32'd2);
      check("stall_ipc", bus.if_pc, 32'd1);
      check("stall_cnt", {16'd0, bus.fetch_count}, 32'd2);
      run(1);
      check("stall_release", bus.if_pc, 32'd2);

      // Branch beats simultaneous stall and flush.
      step(0, 1, 1, 1, 32'h40);
      check("br_pc", bus.pc, 32'h40);
      check("br_bubble", {31'd0, bus.if_valid}, 32'd0);
      run(1);
      check("br_ipc", bus.if_pc, 32'h40);
      check("br_valid", {31'd0, bus.if_valid}, 32'd1);

      // Address wrap from 255 to 256.
      step(0, 0, 0, 1, 32'd255);
      run(1);
      check("wrap_pc", bus.pc, 32'd256);
      check("wrap_addr", {24'd0, bus.imem_addr}, 32'd0);
      check("wrap_ipc", bus.if_pc, 32'd255);

      // Halt word at address 5.
      step(1, 0, 0, 0, 0);
      run(6);
      check("halt_flag", {31'd0, bus.halted}, {31'd0, HEN});
      check("halt_valid", {31'd0, bus.if_valid}, {31'd0, !HEN});
      if (HEN) begin
         for (int i = 0; i < 10; i++) step(0, i[0], i[1], 0, 0);
         check("halt_pc", bus.pc, 32'd5);
         check("halt_cnt", {16'd0, bus.fetch_count}, 32'd5);
      end else begin
         check("nohalt_ipc", bus.if_pc, 32'd5);
      end
      step(0, 0, 0, 1, 32'h10);
      check("unhalt", {31'd0, bus.halted}, 32'd0);
      run(1);
      check("unhalt_ipc", bus.if_pc, 32'h10);

      // Reset during halt and during stall.
      step(0, 0, 0, 1, 32'd5);
      run(2);
      step(1, 1, 1, 0, 0);
      check("rst_halt", {31'd0, bus.halted}, 32'd0);
      check("rst_halt_pc", bus.pc, 32'd0);
      run(3);
      step(0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      check("rst_stall_cnt", {16'd0, bus.fetch_count}, 32'd0);
      check("rst_stall_ipc", bus.if_pc, 32'd0);

      // Random control traffic with a few extra halt words.
      for (int i = 0; i < 6; i++) imem[$urandom_range(10, 255)] = 32'h0;
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                            : $urandom_range(0, 300);
         step($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, tgt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
